// File: rtl/alu_seq_pkg.sv
// Shared types for the calculator ALU sequencer.
// ALU_SEQ_DIV_EN enables the iterative divider.
package alu_seq_pkg;

    localparam int ALU_SEQ_W = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_MUL  = 3'd4,
        OP_DIV  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_iter.sv
// Shift-add multiplier / restoring divider on one shared adder.
// Divider present only when ALU_SEQ_DIV_EN is defined.
module alu_iter
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_SEQ_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_lo,
    output logic [W-1:0] acc_hi
);

    logic [W-1:0] lo_q, lo_d, hi_q, hi_d, m_q, m_d;

`ifdef ALU_SEQ_DIV_EN
    logic [W+1:0] opx, opy, sum;

    // mode=1 subtracts (divide), mode=0 adds (multiply)
    always_comb begin
        opx = mode ? {1'b0, hi_q, lo_q[W-1]} : {2'b00, hi_q};
        opy = (mode || lo_q[0]) ? {2'b00, m_q} : '0;
        sum = opx + (opy ^ {(W+2){mode}}) + (W+2)'(mode);
        if (mode) begin
            if (!sum[W+1]) begin
                acc_hi = sum[W-1:0];
                acc_lo = {lo_q[W-2:0], 1'b1};
            end else begin
                acc_hi = opx[W-1:0];
                acc_lo = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            acc_hi = sum[W:1];
            acc_lo = {sum[0], lo_q[W-1:1]};
        end
    end
`else
    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {W{1'b0}})};
        acc_hi = sum[W:1];
        acc_lo = {sum[0], lo_q[W-1:1]};
    end
`endif

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        m_d  = m_q;
        if (load) begin
            hi_d = '0;
            lo_d = mode ? a : b;
            m_d  = mode ? b : a;
        end else if (step) begin
            lo_d = acc_lo;
            hi_d = acc_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q <= '0;
            hi_q <= '0;
            m_q  <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            m_q  <= m_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Calculator ALU sequencer: FSM, single-cycle datapath, output regs.
// ALU_SEQ_DIV_EN enables DIV; otherwise DIV behaves as reserved.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_SEQ_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op_code,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         abort,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         carry,
    output logic         zero,
    output logic         err
);

    localparam int CW = $clog2(W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    op_t            op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   res_q, res_d, hi_q, hi_d;
    logic           carry_q, carry_d, zero_q, zero_d, err_q, err_d;

    logic [W-1:0]   ex_res, ex_hi;
    logic           ex_carry, ex_err;
    logic           is_iter, iter_load, iter_step, iter_mode;
    logic [W-1:0]   acc_lo, acc_hi;

    alu_iter #(.W(W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .step   (iter_step),
        .load   (iter_load),
        .mode   (iter_mode),
        .a      (op_a),
        .b      (op_b),
        .acc_lo (acc_lo),
        .acc_hi (acc_hi)
    );

`ifdef ALU_SEQ_DIV_EN
    assign is_iter = (op_t'(op_code) == OP_MUL) ||
                     (op_t'(op_code) == OP_DIV && op_b != '0);
`else
    assign is_iter = (op_t'(op_code) == OP_MUL);
`endif

    assign iter_mode = (state_q == S_IDLE) ? (op_t'(op_code) == OP_DIV)
                                           : (op_q == OP_DIV);

    always_comb begin
        ex_res   = '0;
        ex_hi    = '0;
        ex_carry = 1'b0;
        ex_err   = 1'b0;
        case (op_q)
            OP_ADD: {ex_carry, ex_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                ex_res   = a_q - b_q;
                ex_carry = a_q < b_q;
            end
            OP_AND: ex_res = a_q & b_q;
            OP_OR:  ex_res = a_q | b_q;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                ex_res = '1;
                ex_hi  = a_q;
                ex_err = 1'b1;
            end
`endif
            default: ex_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        hi_d      = hi_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                op_d      = op_t'(op_code);
                a_d       = op_a;
                b_d       = op_b;
                iter_load = 1'b1;
                if (is_iter) begin
                    state_d = S_ITER;
                    cnt_d   = CW'(W - 1);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = ex_res;
                hi_d    = ex_hi;
                carry_d = ex_carry;
                zero_d  = (ex_res == '0);
                err_d   = ex_err;
                state_d = S_DONE;
            end
            S_ITER: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    res_d   = acc_lo;
                    hi_d    = acc_hi;
                    carry_d = (op_q == OP_MUL) && (acc_hi != '0);
                    zero_d  = (acc_lo == '0);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort beats everything, including a same-cycle start
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
            hi_d    = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = !ready;
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
// DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [2:0]  op_code;
    logic [15:0] op_a, op_b;
    logic        ready, busy, done, carry, zero, err;
    logic [15:0] result, result_hi;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_first, done_last, done_cnt;
    logic        rdy1, ab_ready;
    logic [34:0] ab_out, obs;
    logic [2:0]  r_op;
    logic [15:0] r_a, r_b;

    alu_sequencer #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .abort     (abort),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    // start in cycle 0; optional second start / abort in given cycles
    task automatic run_op(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int rs_cyc,
                          input int ab_cyc);
        done_first = -1;
        done_last  = -1;
        done_cnt   = 0;
        rdy1       = 1'b1;
        @(negedge clk);
        start = 1'b1; op_code = op; op_a = a; op_b = b;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (c == 1) rdy1 = ready;
            if (done) begin
                if (done_first < 0) done_first = c;
                done_last = c;
                done_cnt++;
            end
            if (c == ab_cyc + 1) begin
                ab_ready = ready;
                ab_out   = {result, result_hi, carry, zero, err};
            end
            if (c == rs_cyc) begin
                start = 1'b1; op_code = r_op; op_a = r_a; op_b = r_b;
            end
            if (c == ab_cyc) abort = 1'b1;
        end
        obs = {result, result_hi, carry, zero, err};
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        op_code = 3'd0; op_a = '0; op_b = '0;
        #12;
        n_chk++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 100", {ready, busy, done});
        end
        obs = {result, result_hi, carry, zero, err};
        n_chk++;
        if (obs !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_out got %h exp 0", obs);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        run_op(3'd0, 16'hFFFF, 16'h0001, -1, -1);
        n_chk++;
        if (done_first !== 2 || done_cnt !== 1 || rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_timing got cyc %0d cnt %0d rdy1 %b exp 2 1 0",
                     done_first, done_cnt, rdy1);
        end
        n_chk++;
        if (obs !== {16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_out got %h exp %h", obs,
                     {16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_sub();
        run_op(3'd1, 16'h0003, 16'h0005, -1, -1);
        n_chk++;
        if (done_first !== 2 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL sub_timing got cyc %0d cnt %0d exp 2 1",
                     done_first, done_cnt);
        end
        n_chk++;
        if (obs !== {16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_out got %h exp %h", obs,
                     {16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_mul();
        r_op = 3'd0; r_a = 16'h0001; r_b = 16'h0001;
        run_op(3'd4, 16'h1234, 16'h0100, 8, -1);
        n_chk++;
        if (done_first !== 17 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL mul_timing got cyc %0d cnt %0d exp 17 1",
                     done_first, done_cnt);
        end
        n_chk++;
        if (obs !== {16'h3400, 16'h0012, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_out got %h exp %h", obs,
                     {16'h3400, 16'h0012, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_div();
`ifdef ALU_SEQ_DIV_EN
        int          exp_cyc = 17;
        logic [34:0] exp_out = {16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0};
`else
        int          exp_cyc = 2;
        logic [34:0] exp_out = {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
`endif
        run_op(3'd5, 16'h0064, 16'h0007, -1, -1);
        n_chk++;
        if (done_first !== exp_cyc || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL div_timing got cyc %0d cnt %0d exp %0d 1",
                     done_first, done_cnt, exp_cyc);
        end
        n_chk++;
        if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL div_out got %h exp %h", obs, exp_out);
        end
    endtask

    task automatic test_div_zero();
`ifdef ALU_SEQ_DIV_EN
        logic [34:0] exp_out = {16'hFFFF, 16'h0064, 1'b0, 1'b0, 1'b1};
`else
        logic [34:0] exp_out = {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
`endif
        run_op(3'd5, 16'h0064, 16'h0000, -1, -1);
        n_chk++;
        if (done_first !== 2 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL divz_timing got cyc %0d cnt %0d exp 2 1",
                     done_first, done_cnt);
        end
        n_chk++;
        if (obs !== exp_out) begin
            n_fail++;
            $display("FAIL divz_out got %h exp %h", obs, exp_out);
        end
    endtask

    task automatic test_reserved();
        run_op(3'd7, 16'h1111, 16'h2222, -1, -1);
        n_chk++;
        if (done_first !== 2 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL rsv_timing got cyc %0d cnt %0d exp 2 1",
                     done_first, done_cnt);
        end
        n_chk++;
        if (obs !== {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rsv_out got %h exp %h", obs,
                     {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_abort();
        run_op(3'd4, 16'h00FF, 16'h00FF, -1, 5);
        n_chk++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_done got cnt %0d exp 0", done_cnt);
        end
        n_chk++;
        if (ab_ready !== 1'b1 || ab_out !== 35'h0) begin
            n_fail++;
            $display("FAIL abort_clear got rdy %b out %h exp 1 0",
                     ab_ready, ab_out);
        end
    endtask

    task automatic test_back_to_back();
        r_op = 3'd3; r_a = 16'h00F0; r_b = 16'h0F00;
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 3, -1);
        n_chk++;
        if (done_first !== 2 || done_last !== 5 || done_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_timing got %0d %0d cnt %0d exp 2 5 2",
                     done_first, done_last, done_cnt);
        end
        n_chk++;
        if (obs !== {16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_out got %h exp %h", obs,
                     {16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op_code = 3'd4; op_a = 16'h0003; op_b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        obs = {result, result_hi, carry, zero, err};
        if ({ready, busy, done} !== 3'b100 || obs !== 35'h0) begin
            n_fail++;
            $display("FAIL rst_mid got ctl %b out %h exp 100 0",
                     {ready, busy, done}, obs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after got rdy %b done %b exp 1 0",
                     ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_zero();
        test_reserved();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
